stage_memory_store_unit: RTL

STAGE_MEMORY_STORE_UNIT -- requirements
Module: stage_memory_store_unit

---
 rtl/stage_memory_store_unit_pkg.sv | 27 ++
 rtl/stage_memory_store_unit_aligner.sv | 35 +++
 rtl/stage_memory_store_unit.sv | 115 +++++++++++
 3 files changed

// File: rtl/stage_memory_store_unit_pkg.sv
// Shared types for the memory store stage: request format, write widths and FSM states.
package stage_memory_store_unit_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    WIDTH_BYTE = 2'd0,
    WIDTH_HALF = 2'd1,
    WIDTH_WORD = 2'd2
  } write_width_t;

  typedef struct packed {
    logic              enable;
    logic [XLEN-1:0]   addr;
    logic [XLEN-1:0]   value;
    write_width_t      width;
  } mem_write_control_t;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RAM_WRITE = 3'd1,
    ST_MMIO_WAIT = 3'd2,
    ST_DONE      = 3'd3,
    ST_FAULT     = 3'd4
  } store_state_t;

endpackage

// File: rtl/stage_memory_store_unit_aligner.sv
// Combinational byte-lane placement and alignment check for a single store request.
module store_lane_aligner
  import stage_memory_store_unit_pkg::*;
(
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] value,
  input  write_width_t    width,
  output logic [XLEN-1:0] word_addr,
  output logic [XLEN-1:0] lane_data,
  output logic [3:0]      byte_en,
  output logic            misaligned
);

  always_comb begin
    word_addr  = {addr[XLEN-1:2], 2'b00};
    lane_data  = value;
    byte_en    = 4'b1111;
    misaligned = (addr[1:0] != 2'b00);
    case (width)
      WIDTH_BYTE: begin
        // Replicate into every lane so the byte enable alone selects the target.
        lane_data  = {4{value[7:0]}};
        byte_en    = 4'b0001 << addr[1:0];
        misaligned = 1'b0;
      end
      WIDTH_HALF: begin
        lane_data  = {2{value[15:0]}};
        byte_en    = addr[1] ? 4'b1100 : 4'b0011;
        misaligned = addr[0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/stage_memory_store_unit.sv
// Store stage: routes a store to RAM (single strobe) or MMIO (wait for acknowledge with timeout).
module stage_memory_store_unit
  import stage_memory_store_unit_pkg::*;
#(
  parameter logic [31:0] ram_start_addr      = 32'h00020000,
  parameter logic [31:0] mmio_start_addr     = 32'h00030000,
  parameter int          mmio_timeout_cycles = 255
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  mem_write_control_t control_store,
  input  logic               mmio_write_complete,
  output logic [XLEN-1:0]    mem_addr,
  output logic [XLEN-1:0]    mem_w_data,
  output logic [3:0]         mem_w_byte_en,
  output logic               mem_w_enable,
  output mem_write_control_t mmio_control,
  output logic               is_complete,
  output logic               misaligned_fault,
  output logic               timeout_fault
);

  localparam logic [31:0] COUNT_LIMIT = 32'(mmio_timeout_cycles - 1);

  store_state_t       state_reg, state_next;
  mem_write_control_t ctrl_reg;
  logic [31:0]        wait_count_reg;
  logic               misaligned_fault_reg;
  logic               timeout_fault_reg;

  mem_write_control_t aligner_src;
  logic [XLEN-1:0]    word_addr, lane_data;
  logic [3:0]         byte_en;
  logic               misaligned;
  logic               is_mmio_req;
  logic               ram_write;

  // In IDLE the aligner classifies the incoming request; afterwards it serves the latched one.
  assign aligner_src = (state_reg == ST_IDLE) ? control_store : ctrl_reg;

  store_lane_aligner u_aligner (
    .addr       (aligner_src.addr),
    .value      (aligner_src.value),
    .width      (aligner_src.width),
    .word_addr  (word_addr),
    .lane_data  (lane_data),
    .byte_en    (byte_en),
    .misaligned (misaligned)
  );

  // An IO window configured below RAM is treated as absent.
  assign is_mmio_req = (control_store.addr >= mmio_start_addr) &&
                       (mmio_start_addr > ram_start_addr);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (enable) begin
          if (!control_store.enable) state_next = ST_DONE;
          else if (misaligned)       state_next = ST_FAULT;
          else if (is_mmio_req)      state_next = ST_MMIO_WAIT;
          else                       state_next = ST_RAM_WRITE;
        end
      end
      ST_RAM_WRITE: state_next = ST_DONE;
      ST_MMIO_WAIT: begin
        if (mmio_write_complete)            state_next = ST_DONE;
        else if (wait_count_reg == COUNT_LIMIT) state_next = ST_FAULT;
      end
      ST_DONE, ST_FAULT: begin
        if (!enable) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg            <= ST_IDLE;
      ctrl_reg             <= '0;
      wait_count_reg       <= '0;
      misaligned_fault_reg <= 1'b0;
      timeout_fault_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_reg == ST_IDLE && enable) ctrl_reg <= control_store;
      wait_count_reg <= (state_reg == ST_MMIO_WAIT) ? wait_count_reg + 32'd1 : 32'd0;
      if (state_next == ST_IDLE) begin
        misaligned_fault_reg <= 1'b0;
        timeout_fault_reg    <= 1'b0;
      end else if (state_next == ST_FAULT) begin
        if (state_reg == ST_IDLE)      misaligned_fault_reg <= 1'b1;
        if (state_reg == ST_MMIO_WAIT) timeout_fault_reg    <= 1'b1;
      end
    end
  end

  assign ram_write     = (state_reg == ST_RAM_WRITE);
  assign mem_w_enable  = ram_write;
  assign mem_addr      = ram_write ? word_addr : '0;
  assign mem_w_data    = ram_write ? lane_data : '0;
  assign mem_w_byte_en = ram_write ? byte_en : 4'b0000;

  always_comb begin
    mmio_control        = ctrl_reg;
    mmio_control.enable = (state_reg == ST_MMIO_WAIT);
  end

  assign is_complete      = (state_reg == ST_DONE) || (state_reg == ST_FAULT);
  assign misaligned_fault = misaligned_fault_reg;
  assign timeout_fault    = timeout_fault_reg;

endmodule
